// File: rtl/fetch_pkg.sv
// Shared widths, FSM states and the buffered-instruction record for the fetch unit.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with an unreset storage array; the head word is read straight from storage.
// Serves as both the decode-side instruction buffer and the in-flight fetch address queue.
module fetch_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full buffer is accepted when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues in-order requests at pc, steers the PC register input, and buffers
// returned instructions for decode while discarding responses orphaned by a redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [OCW-1:0]  outstanding;
  logic [OCW-1:0]  stale;
  logic [OCW-1:0]  stale_next;
  logic [FCW-1:0]  buf_count;
  logic            buf_full;
  logic            buf_empty;
  logic            pq_full;
  logic            pq_empty;
  logic [PC_W-1:0] pq_head;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_in;
  logic [31:0]     inflight;
  logic            credit_ok;
  logic            fire;
  logic            rsp_ok;
  logic            buf_push;
  logic            buf_pop;

  // Every issued request reserves a buffer slot until its instruction is consumed.
  assign inflight  = 32'(outstanding) + 32'(buf_count);
  assign credit_ok = (inflight < 32'(FIFO_DEPTH)) && !buf_full && !pq_full;

  // A response with nothing in flight is a protocol violation and is ignored.
  assign rsp_ok = imem_rsp_valid & ~pq_empty;

  assign imem_req_valid = rst & credit_ok & (state == RUN) & ~redirect_valid;
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid & imem_req_ready;

  always_comb begin
    pc_next = pc;
    if (!rst)                pc_next = RESET_PC;
    else if (redirect_valid) pc_next = redirect_pc;
    else if (fire)           pc_next = pc + PC_STEP;
  end

  assign buf_in   = '{pc: pq_head, instr: imem_rsp_data};
  assign buf_push = rsp_ok & (state == RUN);
  assign buf_pop  = instr_valid & instr_ready;

  assign instr_valid = rst & ~buf_empty;
  assign instr       = rst ? buf_head.instr : '0;
  assign instr_pc    = rst ? buf_head.pc    : '0;

  fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .DATA_W(PC_W)) u_pc_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .pop   (rsp_ok),
    .clear (1'b0),
    .wdata (pc),
    .rdata (pq_head),
    .count (outstanding),
    .full  (pq_full),
    .empty (pq_empty)
  );

  // Redirect clears the buffer, which also cancels a same-cycle push.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W($bits(fetch_entry_t))) u_instr_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .clear (redirect_valid),
    .wdata (buf_in),
    .rdata (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      stale <= '0;
    end else begin
      state <= state_next;
      stale <= stale_next;
    end
  end

  always_comb begin
    state_next = state;
    stale_next = stale;
    if (redirect_valid) begin
      stale_next = outstanding - OCW'(rsp_ok);
      state_next = (stale_next != '0) ? DRAIN : RUN;
    end else if (state == DRAIN && rsp_ok) begin
      stale_next = stale - OCW'(1);
      if (stale_next == '0) state_next = RUN;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC register, in-order memory with configurable latency, and an
// epoch-tagged reference model of the instruction stream seen by decode.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam int          MAX_OUT    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  mreq_t       memq[$];
  ent_t        fq[$];
  logic [31:0] delivered[$];
  logic [31:0] fires[$];
  logic [31:0] rnd;
  int checks, errors, epoch, cyc, last_due, lat, first_fire, first_iv;

  always #5 clk = ~clk;

  // The PC register that this unit feeds.
  always_ff @(posedge clk) pc <= pc_next;

  instr_fetch_unit #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_next        (pc_next),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEE1;
  endfunction

  // One clock cycle: drive memory response, check outputs against the model, advance the model.
  task automatic step();
    logic        stale_any;
    logic        exp_req;
    logic        exp_fire;
    logic [31:0] exp_pcn;
    mreq_t       h;
    int          d;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #2;
    if (!rst) begin
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_pc_next", pc_next, RESET_PC);
      memq.delete();
      fq.delete();
      last_due = cyc;
    end else begin
      stale_any = 1'b0;
      foreach (memq[i]) if (memq[i].epoch != epoch) stale_any = 1'b1;
      exp_req  = !redirect_valid && !stale_any &&
                 (memq.size() + fq.size() < FIFO_DEPTH) && (memq.size() < MAX_OUT);
      exp_fire = exp_req && imem_req_ready;
      exp_pcn  = redirect_valid ? redirect_pc : (exp_fire ? pc + 32'd4 : pc);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
      chk("req_addr", imem_req_addr, pc);
      chk("pc_next", pc_next, exp_pcn);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, fq.size() > 0});
      if (fq.size() > 0) begin
        chk("instr_pc", instr_pc, fq[0].pc);
        chk("instr", instr, fq[0].word);
      end
      if (instr_valid === 1'b1 && instr_ready) delivered.push_back(instr_pc);
      if (imem_req_valid === 1'b1 && imem_req_ready) fires.push_back(imem_req_addr);
      if (exp_fire && first_fire < 0) first_fire = cyc;
      if (instr_valid === 1'b1 && first_iv < 0) first_iv = cyc;
      if (fq.size() > 0 && instr_ready) void'(fq.pop_front());
      if (imem_rsp_valid) begin
        h = memq.pop_front();
        if (h.epoch == epoch && !redirect_valid) fq.push_back('{h.addr, h.data});
      end
      if (redirect_valid) begin
        fq.delete();
        epoch++;
      end
      if (exp_fire) begin
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        memq.push_back('{pc, $urandom, epoch, d});
        last_due = d;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic restart(input int n);
    rst = 1'b0;
    redirect_valid = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; epoch = 0; cyc = 0; last_due = 0; lat = 1;
    first_fire = -1; first_iv = -1;
    rst = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;

    // Straight-line fetch with a 1-cycle memory.
    imem_req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
    restart(3);
    delivered.delete(); first_fire = -1; first_iv = -1;
    repeat (12) step();
    chk("seq0", at(delivered, 0), 32'h0);
    chk("seq1", at(delivered, 1), 32'h4);
    chk("seq2", at(delivered, 2), 32'h8);
    chk("seq3", at(delivered, 3), 32'hC);
    chk("iv_latency", 32'(first_iv - first_fire), 32'd2);

    // Decode stall fills the buffer and blocks issue.
    instr_ready = 1'b0;
    restart(2);
    delivered.delete();
    repeat (6) step();
    chk("stall_pc", pc, 32'h8);
    chk("stall_req", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_iv", {31'b0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    repeat (10) step();
    chk("drain0", at(delivered, 0), 32'h0);
    chk("drain1", at(delivered, 1), 32'h4);
    chk("resume", at(delivered, 2), 32'h8);

    // Redirect with two requests in flight.
    lat = 3;
    restart(2);
    repeat (2) step();
    chk("two_out_req", {31'b0, imem_req_valid}, 32'd0);
    delivered.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("drain_req", {31'b0, imem_req_valid}, 32'd0);
    repeat (14) step();
    chk("redir_first", at(delivered, 0), 32'h100);
    chk("redir_second", at(delivered, 1), 32'h104);

    // Redirect in the same cycle as a response.
    lat = 2;
    restart(2);
    repeat (2) step();
    delivered.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("same_cyc_drop", {31'b0, instr_valid}, 32'd0);
    chk("same_cyc_drain", {31'b0, imem_req_valid}, 32'd0);
    repeat (10) step();
    chk("same_cyc_first", at(delivered, 0), 32'h200);

    // PC wrap at the top of the address space.
    lat = 1;
    restart(2);
    fires.delete(); delivered.delete();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    repeat (8) step();
    chk("wrap0", at(fires, 0), 32'hFFFF_FFFC);
    chk("wrap1", at(fires, 1), 32'h0);
    chk("wrap_instr", at(delivered, 0), 32'hFFFF_FFFC);

    // Reset while draining stale responses.
    lat = 4;
    restart(2);
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    chk("drain_state_req", {31'b0, imem_req_valid}, 32'd0);
    restart(2);
    delivered.delete(); fires.delete();
    repeat (14) step();
    chk("post_rst_fire", at(fires, 0), RESET_PC);
    chk("post_rst_instr", at(delivered, 0), RESET_PC);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      imem_req_ready = ($urandom_range(3) != 0);
      instr_ready    = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(11) == 0);
      rnd            = $urandom;
      redirect_pc    = {rnd[31:2], 2'b00};
      if (i % 100 == 0) lat = $urandom_range(4, 1);
      rst            = ($urandom_range(199) != 0);
      step();
    end
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
